// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection (optional HAZARD_PERF_CNT_EN counters)
module id_ex_stage #(
  parameter int XLEN   = 64,
  parameter int REGIDX = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   ID_pc,
  input  logic [XLEN-1:0]   ID_rd1,
  input  logic [XLEN-1:0]   ID_rd2,
  input  logic [XLEN-1:0]   ID_imm,
  input  logic [REGIDX-1:0] IF_ID_rs1,
  input  logic [REGIDX-1:0] IF_ID_rs2,
  input  logic [REGIDX-1:0] ID_rd,
  input  logic [3:0]        ID_funct4,
  input  logic [7:0]        ID_ctrl,
  input  logic              flush,
  output logic              stall,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic [XLEN-1:0]   ID_EX_rd1,
  output logic [XLEN-1:0]   ID_EX_rd2,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [REGIDX-1:0] ID_EX_rs1,
  output logic [REGIDX-1:0] ID_EX_rs2,
  output logic [REGIDX-1:0] ID_EX_rd,
  output logic [3:0]        ID_EX_funct4,
  output logic [7:0]        ID_EX_ctrl,
  output logic              ID_EX_valid
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
`endif
);

  // ctrl bit 6 is MemRead in {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
  localparam int CTRL_MEMREAD = 6;

  logic hazard;
  logic bubble;

  // Load in EX whose destination is a source of the instruction in ID; bubbles never qualify
  always_comb begin
    hazard = ID_EX_ctrl[CTRL_MEMREAD] & ID_EX_valid & (ID_EX_rd != '0) &
             ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2));
    stall  = hazard & ~flush;
    bubble = flush | hazard;
  end

  // Pipeline register: datapath always loads, control is zeroed on flush or load-use bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ID_EX_pc     <= '0;
      ID_EX_rd1    <= '0;
      ID_EX_rd2    <= '0;
      ID_EX_imm    <= '0;
      ID_EX_rs1    <= '0;
      ID_EX_rs2    <= '0;
      ID_EX_rd     <= '0;
      ID_EX_funct4 <= '0;
      ID_EX_ctrl   <= '0;
      ID_EX_valid  <= 1'b0;
    end else begin
      ID_EX_pc     <= ID_pc;
      ID_EX_rd1    <= ID_rd1;
      ID_EX_rd2    <= ID_rd2;
      ID_EX_imm    <= ID_imm;
      ID_EX_rs1    <= IF_ID_rs1;
      ID_EX_rs2    <= IF_ID_rs2;
      ID_EX_rd     <= ID_rd;
      ID_EX_funct4 <= ID_funct4;
      ID_EX_ctrl   <= bubble ? 8'h00 : ID_ctrl;
      ID_EX_valid  <= ~bubble;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters for stalls and flushes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != 32'hFFFF_FFFF)) stall_count <= stall_count + 32'd1;
      if (flush && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] ID_pc, ID_rd1, ID_rd2, ID_imm;
  logic [4:0]  IF_ID_rs1, IF_ID_rs2, ID_rd;
  logic [3:0]  ID_funct4;
  logic [7:0]  ID_ctrl;
  logic        flush;
  logic        stall;
  logic [63:0] ID_EX_pc, ID_EX_rd1, ID_EX_rd2, ID_EX_imm;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [3:0]  ID_EX_funct4;
  logic [7:0]  ID_EX_ctrl;
  logic        ID_EX_valid;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  id_ex_stage #(.XLEN(64), .REGIDX(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .ID_pc(ID_pc), .ID_rd1(ID_rd1), .ID_rd2(ID_rd2), .ID_imm(ID_imm),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .ID_rd(ID_rd),
    .ID_funct4(ID_funct4), .ID_ctrl(ID_ctrl), .flush(flush),
    .stall(stall),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rd1(ID_EX_rd1), .ID_EX_rd2(ID_EX_rd2), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_funct4(ID_EX_funct4), .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_valid(ID_EX_valid)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the instruction currently sitting in EX
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [3:0]  m_f4;
  logic [63:0] m_pc, m_rd1, m_rd2, m_imm;
  int          m_stalls, m_flushes;

  typedef struct {
    logic [7:0] ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       fl;
    logic       exp_stall;
    logic       exp_valid;
    logic [7:0] exp_ctrl;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_f4 = 0;
    m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    m_stalls = 0; m_flushes = 0;
  endtask

  // A load in EX blocks any ID instruction reading its (non-zero) destination
  function automatic logic model_load_use(input logic [4:0] rs1, input logic [4:0] rs2);
    return m_valid && m_ctrl[6] && (m_rd != 0) && (m_rd == rs1 || m_rd == rs2);
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".pc"},     ID_EX_pc,     m_pc);
    chk({tag, ".rd1"},    ID_EX_rd1,    m_rd1);
    chk({tag, ".rd2"},    ID_EX_rd2,    m_rd2);
    chk({tag, ".imm"},    ID_EX_imm,    m_imm);
    chk({tag, ".rs1"},    64'(ID_EX_rs1),    64'(m_rs1));
    chk({tag, ".rs2"},    64'(ID_EX_rs2),    64'(m_rs2));
    chk({tag, ".rd"},     64'(ID_EX_rd),     64'(m_rd));
    chk({tag, ".funct4"}, 64'(ID_EX_funct4), 64'(m_f4));
    chk({tag, ".ctrl"},   64'(ID_EX_ctrl),   64'(m_ctrl));
    chk({tag, ".valid"},  64'(ID_EX_valid),  64'(m_valid));
  endtask

  // One pipeline cycle, entered and left 1 time unit after a rising edge
  task automatic run_cycle(input string tag, input logic [7:0] ctrl, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic fl,
                           output logic got_stall, output logic got_valid, output logic [7:0] got_ctrl);
    logic squash;
    ID_ctrl = ctrl; ID_rd = rd; IF_ID_rs1 = rs1; IF_ID_rs2 = rs2; flush = fl;
    ID_pc = {$urandom, $urandom}; ID_rd1 = {$urandom, $urandom};
    ID_rd2 = {$urandom, $urandom}; ID_imm = {$urandom, $urandom};
    ID_funct4 = 4'($urandom);
    #3;
    squash = fl || model_load_use(rs1, rs2);
    chk({tag, ".stall"}, 64'(stall), 64'(model_load_use(rs1, rs2) && !fl));
    got_stall = stall;
    if (model_load_use(rs1, rs2) && !fl) m_stalls++;
    if (fl) m_flushes++;
    @(posedge clk);
    m_pc = ID_pc; m_rd1 = ID_rd1; m_rd2 = ID_rd2; m_imm = ID_imm;
    m_rs1 = rs1; m_rs2 = rs2; m_rd = rd; m_f4 = ID_funct4;
    m_ctrl  = squash ? 8'h00 : ctrl;
    m_valid = !squash;
    #1;
    check_regs(tag);
    got_valid = ID_EX_valid;
    got_ctrl  = ID_EX_ctrl;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".stall"}, 64'(stall), 64'd0);
    check_regs(tag);
  endtask

  logic       s, v;
  logic [7:0] c;

  initial begin
    reset_n = 1'b0;
    ID_pc = 0; ID_rd1 = 0; ID_rd2 = 0; ID_imm = 0;
    IF_ID_rs1 = 0; IF_ID_rs2 = 0; ID_rd = 0; ID_funct4 = 0; ID_ctrl = 8'hFF; flush = 0;
    model_reset();

    // Load-use table: ld = ctrl D0 (RegWrite, MemRead, MemtoReg); ALU op = 80
    vecs.push_back('{8'hD0, 5'd5,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x5
    vecs.push_back('{8'h80, 5'd6,  5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 8'h00}); // uses x5 via rs2 -> stall
    vecs.push_back('{8'h80, 5'd6,  5'd3, 5'd5, 1'b0, 1'b0, 1'b1, 8'h80}); // re-presented
    vecs.push_back('{8'hD0, 5'd0,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x0
    vecs.push_back('{8'h80, 5'd7,  5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h80}); // rs1=0: no stall
    vecs.push_back('{8'hD0, 5'd5,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x5
    vecs.push_back('{8'h80, 5'd8,  5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 8'h80}); // independent
    vecs.push_back('{8'h80, 5'd5,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'h80}); // non-load writes x5
    vecs.push_back('{8'h80, 5'd9,  5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 8'h80}); // reads x5: no stall
    vecs.push_back('{8'hD0, 5'd5,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x5
    vecs.push_back('{8'h80, 5'd10, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 8'h00}); // both match: one stall
    vecs.push_back('{8'h80, 5'd10, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 8'h80});
    vecs.push_back('{8'hD0, 5'd5,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x5
    vecs.push_back('{8'h80, 5'd11, 5'd5, 5'd2, 1'b1, 1'b0, 1'b0, 8'h00}); // flush beats hazard
    vecs.push_back('{8'hD0, 5'd6,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x6
    vecs.push_back('{8'hD0, 5'd7,  5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 8'hD0}); // ld x7: no stall
    vecs.push_back('{8'h80, 5'd12, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0, 8'h00}); // uses x7 -> stall
    vecs.push_back('{8'h80, 5'd12, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0, 8'h00}); // flush over bubble

    // Reset held: everything zero
    @(posedge clk); #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Put a real instruction in EX, then assert reset mid-cycle
    run_cycle("pre", 8'hFF, 5'd5, 5'd1, 5'd2, 1'b0, s, v, c);
    ID_ctrl = 8'hFF; IF_ID_rs1 = 5'd5;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("async_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // First capture after release
    run_cycle("release", 8'h80, 5'd5, 5'd1, 5'd2, 1'b0, s, v, c);
    chk("release.ctrl80", 64'(c), 64'h80);
    chk("release.valid1", 64'(v), 64'd1);
    chk("release.rd5",    64'(ID_EX_rd), 64'd5);

    // Table-driven load-use / x0 / flush vectors
    foreach (vecs[i]) begin
      run_cycle($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                vecs[i].fl, s, v, c);
      chk($sformatf("vec%0d.tstall", i), 64'(s), 64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d.tvalid", i), 64'(v), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.tctrl", i),  64'(c), 64'(vecs[i].exp_ctrl));
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall3", 64'(stall_count), 64'd3);
    chk("perf.flush2", 64'(flush_count), 64'd2);
`endif

    // Passthrough of datapath fields
    ID_ctrl = 8'h23; ID_rd = 5'd9; IF_ID_rs1 = 5'd3; IF_ID_rs2 = 5'd4; flush = 0;
    ID_pc = 64'h1000; ID_imm = 64'hFFFF_FFFF_FFFF_FFF8; ID_funct4 = 4'b1000;
    ID_rd1 = 64'h1111_2222_3333_4444; ID_rd2 = 64'hAAAA_BBBB_CCCC_DDDD;
    @(posedge clk); #1;
    chk("pass.pc",     ID_EX_pc,  64'h1000);
    chk("pass.imm",    ID_EX_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("pass.rd1",    ID_EX_rd1, 64'h1111_2222_3333_4444);
    chk("pass.rd2",    ID_EX_rd2, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("pass.funct4", 64'(ID_EX_funct4), 64'h8);
    chk("pass.rs1",    64'(ID_EX_rs1), 64'd3);
    chk("pass.rs2",    64'(ID_EX_rs2), 64'd4);
    chk("pass.ctrl",   64'(ID_EX_ctrl), 64'h23);
    chk("pass.valid",  64'(ID_EX_valid), 64'd1);
    m_pc = ID_pc; m_rd1 = ID_rd1; m_rd2 = ID_rd2; m_imm = ID_imm; m_f4 = ID_funct4;
    m_rs1 = 5'd3; m_rs2 = 5'd4; m_rd = 5'd9; m_ctrl = 8'h23; m_valid = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [7:0] rc;
      rc = 8'($urandom);
      if ($urandom_range(0, 1) == 0) rc[6] = 1'b1;
      run_cycle($sformatf("rnd%0d", n), rc, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0), s, v, c);
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.stall_total", 64'(stall_count), 64'(m_stalls));
    chk("perf.flush_total", 64'(flush_count), 64'(m_flushes));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV64I pipelined core, with integrated load-use hazard detection.
- Captures decoded operands, immediate, register indices and control bits from ID; presents them to EX and to the forwarding unit (ID_EX_rs1/ID_EX_rs2/ID_EX_rd).
- Generates the stall that freezes PC and IF/ID, inserts a bubble on load-use, and squashes on branch flush.

Parameters:
- XLEN, 64, datapath width (PC, register data, immediate)
- REGIDX, 5, register index width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- ID_pc  input  XLEN  PC of instruction in ID
- ID_rd1  input  XLEN  register file read data 1
- ID_rd2  input  XLEN  register file read data 2
- ID_imm  input  XLEN  generated immediate
- IF_ID_rs1  input  REGIDX  rs1 of instruction in ID
- IF_ID_rs2  input  REGIDX  rs2 of instruction in ID
- ID_rd  input  REGIDX  destination of instruction in ID
- ID_funct4  input  4  {instr[30], funct3}
- ID_ctrl  input  8  {RegWrite, MemRead, MemWrite, MemtoReg, Branch, ALUSrc, ALUOp[1:0]}
- flush  input  1  branch taken resolved downstream; squash ID
- stall  output  1  hold PC and IF/ID this cycle
- ID_EX_pc, ID_EX_rd1, ID_EX_rd2, ID_EX_imm  output  XLEN each  registered copies
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  output  REGIDX each  registered indices
- ID_EX_funct4  output  4  registered funct
- ID_EX_ctrl  output  8  registered control, same bit order
- ID_EX_valid  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset: asynchronous on reset_n low. All registered outputs go to 0, including ID_EX_valid=0 and ID_EX_ctrl=0. Reset mid-operation discards the in-flight instruction. First capture happens on the first rising edge after release.
- hazard (combinational) = ID_EX_ctrl.MemRead & ID_EX_valid & (ID_EX_rd != 0) & ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2)).
- stall = hazard & ~flush. Purely combinational from current register state and ID inputs; no added latency.
- Each rising edge, priority order:
  1. flush=1 → ID_EX_ctrl=0, ID_EX_valid=0. Datapath fields load ID inputs (don't-care). flush beats hazard.
  2. hazard=1 → bubble: ID_EX_ctrl=0, ID_EX_valid=0. Datapath fields still load (the same instruction is re-presented next cycle because IF/ID is held).
  3. else → all fields load from ID inputs; ID_EX_valid=1.
- Latency: 1 cycle ID→EX.
- Load-use costs exactly one bubble. Next cycle ID_EX holds the bubble (MemRead=0), so hazard clears; forwarding then resolves from MEM/WB.
- A bubble never asserts hazard, because ID_EX_valid=0 gates it.
- rd=x0 load never stalls.
- rs1 and rs2 both matching produces a single stall, not two.
- Back-to-back loads to independent registers: no stall.
- The block holds no state besides the pipeline register; the only state transition is valid→bubble→valid.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_count [31:0] and flush_count [31:0]:
  - Both reset to 0 asynchronously.
  - stall_count increments on every edge where stall=1.
  - flush_count increments on every edge where flush=1.
  - Both saturate at 32'hFFFFFFFF (no wrap).
- When undefined, the ports and counters are absent and the block is otherwise identical.

Test Plan:
- Reset: drive reset_n=0 mid-stream with ID_ctrl=8'hFF → all outputs 0 immediately (before the next edge), stall=0. Release, then ID_ctrl=8'h80, ID_rd=5 → next edge ID_EX_ctrl=8'h80, ID_EX_rd=5, ID_EX_valid=1.
- Load-use: ld x5 captured (ctrl MemRead=1, rd=5), then ID presents IF_ID_rs2=5 → stall=1 that cycle. Next edge ID_EX_ctrl=0 and ID_EX_valid=0, stall drops to 0. Following edge captures the dependent instruction with valid=1.
- x0 / no dependence: ld x0 followed by rs1=0 → stall=0. ld x5 followed by rs1=6, rs2=7 → stall=0. A non-load writing x5 followed by rs1=5 → stall=0.
- Flush priority: ld x5 in EX, IF_ID_rs1=5, flush=1 → stall=0; next edge ID_EX_ctrl=0, valid=0.
- Passthrough: ID_pc=64'h1000, ID_imm=64'hFFFF_FFFF_FFFF_FFF8, funct4=4'b1000, rs1=3, rs2=4 → all appear unchanged on ID_EX_* after one edge.
- HAZARD_PERF_CNT_EN: 3 load-use events and 2 flushes → stall_count=3, flush_count=2. Preload near max → counters hold at 32'hFFFFFFFF.
